pipeline_hazard_ctrl: RTL

- Central hazard controller for the 5-stage pipeline CPU.
- Generates EXE-stage operand forwarding selects from MEM and WB.
- Detects load-use hazards and inserts a one-cycle bubble; flushes IF/ID on a taken branch resolved in EXE.
- Schedules the multi-cycle multiply/divide unit (MDU), stalling ID while HI/LO results are pending; keeps a stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Hazard controller for a 5-stage pipeline. Handles forwarding,
//            load-use bubbles, branch flushes, MDU scheduling and a stall counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_mdu_use,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_is_mul,
    input  logic        ex_is_div,
    input  logic        ex_branch_taken,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_count
);

    localparam logic [7:0] C_MUL_CNT = 8'(MUL_CYCLES);
    localparam logic [7:0] C_DIV_CNT = 8'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;

    logic w_issue;
    logic w_load_use;
    logic w_mdu_stall;
    logic w_stall;

    assign w_issue     = (ex_is_mul || ex_is_div) && (r_state == S_IDLE);
    assign w_load_use  = ex_memread && (ex_rd != 5'd0) &&
                         ((id_uses_rs && (id_rs == ex_rd)) ||
                          (id_uses_rt && (id_rt == ex_rd)));
    assign w_mdu_stall = id_mdu_use && (w_issue || (mdu_busy && !mdu_done));
    assign w_stall     = w_load_use || w_mdu_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src))
            return 2'b10;
        else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!reset) begin
            fwd_a = fwd_sel(ex_rs);
            fwd_b = fwd_sel(ex_rt);
            // A taken branch squashes the stalled ID instruction instead of holding it
            if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (w_stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            mdu_busy    <= 1'b0;
            mdu_done    <= 1'b0;
            stall_count <= 32'd0;
        end else begin
            if (w_stall && !ex_branch_taken && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state  <= S_BUSY;
                        r_cnt    <= ex_is_div ? C_DIV_CNT : C_MUL_CNT;
                        mdu_busy <= 1'b1;
                        mdu_done <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // done is registered one count early so it lands on cnt == 1
                    r_cnt    <= r_cnt - 8'd1;
                    mdu_done <= (r_cnt == 8'd2);
                    if (r_cnt == 8'd1) begin
                        r_state  <= S_IDLE;
                        mdu_busy <= 1'b0;
                        mdu_done <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    mdu_busy <= 1'b0;
                    mdu_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
